command_queue: RTL and testbench
================================

# command_queue

Two-word command assembler and FIFO between the ROM fetch stage and the decode stage of the pipelined CPU. It collects consecutive DATA_W-wide ROM words written by fetch (comm_write), packs each pair into one 2*DATA_W command and queues it. Decode pops commands with comm_read. The block generates pause_READ (queue full) and pause_DECODE (queue empty) for those stages, and discards queued contents on a taken jump.

## Interface
- DATA_W, 14, width of one ROM word
- DEPTH, 8, command entries; power of two, at least 2
- PTR_W, 3, log2(DEPTH)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- comm_write  in  1  push strobe: one ROM word on word_in
- word_in  in  DATA_W  ROM data word
- comm_read  in  1  pop strobe from decode
- flush  in  1  taken jump: discard queue and half-assembled command
- command_out  out  2*DATA_W  head command; first word in [2*DATA_W-1:DATA_W], second in [DATA_W-1:0]
- pause_READ  out  1  queue full; fetch must not write
- pause_DECODE  out  1  queue empty; decode must not read
- half_pending  out  1  first word of a command held, second not yet received
- count  out  PTR_W+1  number of complete commands queued
- overflow  out  1  sticky: a write was dropped
- underflow  out  1  sticky: a read was ignored

## Operation
- Reset values (asynchronous, while reset=0):
  - pointers = 0; count = 0; half_pending = 0
  - pause_READ = 0; pause_DECODE = 1
  - overflow = 0; underflow = 0; command_out = 0
- Assembly on an accepted comm_write:
  - half_pending=0: word_in is latched into the high holding register; half_pending is set.
  - half_pending=1: {high, word_in} is written to mem[wr_ptr]; wr_ptr increments modulo DEPTH; half_pending clears.
- Write acceptance: comm_write is accepted only when pause_READ=0.
  - A comm_write while pause_READ=1 is dropped. State is unchanged and overflow is set.
  - Both halves are blocked when full.
- Read acceptance: comm_read is accepted only when pause_DECODE=0. An accepted read increments rd_ptr modulo DEPTH.
  - A comm_read while empty is ignored and sets underflow.
- Simultaneous completing write and accepted read: the count is unchanged and both pointers advance.
  - When full, the write is still dropped. pause_READ is evaluated on pre-edge state.
- Empty plus completing write plus read in the same cycle: the read is ignored (no bypass) and underflow is set. The write is stored.
- flush takes priority over write and read in the same cycle. It resets the pointers, count and half_pending, does not change overflow or underflow, and does not change stored data.
- Wrap-around: pointers are PTR_W bits and wrap silently. Full/empty are derived from count, not from pointer compare.
- Outputs:
  - command_out = mem[rd_ptr] when count>0, else 0.
  - pause_READ = (count==DEPTH).
  - pause_DECODE = (count==0).
- overflow and underflow clear only on reset.

## Timing
- All state updates occur on the rising clk edge except reset.
- Write-to-read latency: a second word accepted at edge N gives pause_DECODE=0 and a valid command_out during cycle N+1. One cycle minimum.
- pause_READ, pause_DECODE and count reflect post-edge state in the same cycle.
- command_out is combinational from registered storage. It has no read-port register, so decode samples it in the same cycle it asserts comm_read.
- Flush at edge N: queue empty and pause_DECODE=1 from cycle N+1. The first word written at N+1 starts a new command.
- Reset asserted mid-assembly or mid-queue discards everything. Outputs take reset values asynchronously.

## Structure
- The shared CPU package holds DATA_W, CMD_W (2*DATA_W) and the DEPTH default, all consumed by fetch, decode and command_queue.
- Sub-module cmd_fifo_mem holds the register array: DEPTH x CMD_W, one synchronous write port and one asynchronous read port, with no reset on the data array.
- Pointer, count, half-word, pause and flag logic live in command_queue.

## Test plan
- After reset, write words 0x1234 then 0x0ABC → half_pending=1 after the first. After the second, count=1, pause_DECODE=0 and command_out=0x48D0ABC.
- Write 16 words (8 commands, DEPTH=8) → pause_READ=1 and count=8. A 17th write is dropped with overflow=1. Pop 8 times and check commands come out in order, with pause_DECODE=1 after the last pop.
- With the queue full, assert a completing write and comm_read together → the write is dropped and overflow=1. count=7 and rd_ptr advanced by 1.
- Write one word then flush → half_pending=0 and count=0. Then write words 0x0001 and 0x0002 → command_out=0x0004002.
- With the queue empty, complete a write while also asserting comm_read → count=1 and underflow=1. command_out holds the new command in the next cycle.
- Cycle 20 commands through DEPTH=8 to force pointer wrap, then assert reset mid-assembly → the wrapped data is correct, then all outputs match their reset values asynchronously.

Source files
------------

// File: rtl/command_queue_pkg.sv
// Shared CPU constants for fetch, decode and the command queue between them.
package command_queue_pkg;

   localparam int CQ_DATA_W = 14;
   localparam int CQ_CMD_W  = 2 * CQ_DATA_W;
   localparam int CQ_DEPTH  = 8;
   localparam int CQ_PTR_W  = $clog2(CQ_DEPTH);

   typedef logic [CQ_DATA_W-1:0] rom_word_t;
   typedef logic [CQ_CMD_W-1:0]  cmd_t;

   // First ROM word lands in the upper half of the command.
   function automatic cmd_t pack_cmd(input rom_word_t hi, input rom_word_t lo);
      return {hi, lo};
   endfunction

endpackage

// File: rtl/command_queue_if.sv
// Fetch/decode side signals of the command queue, bundled for port hookup.
interface command_queue_if
   import command_queue_pkg::*;
#(
   parameter int DATA_W = CQ_DATA_W,
   parameter int DEPTH  = CQ_DEPTH
);
   localparam int PTR_W = $clog2(DEPTH);

   logic                  comm_write;
   logic [DATA_W-1:0]     word_in;
   logic                  comm_read;
   logic                  flush;
   logic [2*DATA_W-1:0]   command_out;
   logic                  pause_READ;
   logic                  pause_DECODE;
   logic                  half_pending;
   logic [PTR_W:0]        count;
   logic                  overflow;
   logic                  underflow;

   // Driven by fetch/decode (or a bench standing in for them).
   modport master (
      output comm_write, word_in, comm_read, flush,
      input  command_out, pause_READ, pause_DECODE, half_pending,
             count, overflow, underflow
   );

   // The queue itself.
   modport slave (
      input  comm_write, word_in, comm_read, flush,
      output command_out, pause_READ, pause_DECODE, half_pending,
             count, overflow, underflow
   );
endinterface

// File: rtl/command_queue_cmd_fifo_mem.sv
// Command storage: DEPTH x CMD_W registers, synchronous write, asynchronous read.
// The array is deliberately not reset; validity is tracked by the queue count.
module cmd_fifo_mem
   import command_queue_pkg::*;
#(
   parameter int CMD_W = CQ_CMD_W,
   parameter int DEPTH = CQ_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [PTR_W-1:0] waddr_i,
   input  logic [CMD_W-1:0] wdata_i,
   input  logic [PTR_W-1:0] raddr_i,
   output logic [CMD_W-1:0] rdata_o
);

   logic [CMD_W-1:0] mem_q [DEPTH];

   // Store one assembled command per write strobe.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/command_queue.sv
// Two-word command assembler and FIFO between ROM fetch and decode.
// Pairs of ROM words become one command; decode pops commands from the head.
// Full/empty come from the count so pointers can wrap freely.
module command_queue
   import command_queue_pkg::*;
#(
   parameter int DATA_W = CQ_DATA_W,
   parameter int DEPTH  = CQ_DEPTH
) (
   input  logic           clk,
   input  logic           reset,
   command_queue_if.slave cq
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CMD_W = 2 * DATA_W;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] high_q,   high_d;
   logic              half_q,   half_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q,  count_d;
   logic              ovf_q,    ovf_d;
   logic              unf_q,    unf_d;

   logic              full;
   logic              empty;
   logic              wr_acc;
   logic              rd_acc;
   logic              complete;
   logic [CMD_W-1:0]  head_cmd;

   // Acceptance is judged on pre-edge state; flush overrides both strobes.
   always_comb begin
      full     = (count_q == FULL_CNT);
      empty    = (count_q == '0);
      wr_acc   = cq.comm_write & ~full  & ~cq.flush;
      rd_acc   = cq.comm_read  & ~empty & ~cq.flush;
      complete = wr_acc & half_q;

      high_d   = high_q;
      half_d   = half_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;

      if (cq.flush) begin
         // Stored data and sticky flags survive a flush.
         half_d   = 1'b0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_acc) begin
            if (half_q) begin
               wr_ptr_d = wr_ptr_q + PTR_W'(1);
               half_d   = 1'b0;
            end else begin
               high_d = cq.word_in;
               half_d = 1'b1;
            end
         end
         if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({complete, rd_acc})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
         endcase
         // No read bypass: a read against an empty queue is always an underflow.
         if (cq.comm_write && full) begin
            ovf_d = 1'b1;
         end
         if (cq.comm_read && empty) begin
            unf_d = 1'b1;
         end
      end
   end

   // Queue control state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         high_q   <= '0;
         half_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         high_q   <= high_d;
         half_q   <= half_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   cmd_fifo_mem #(
      .CMD_W (CMD_W),
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_mem (
      .clk     (clk),
      .we_i    (complete),
      .waddr_i (wr_ptr_q),
      .wdata_i ({high_q, cq.word_in}),
      .raddr_i (rd_ptr_q),
      .rdata_o (head_cmd)
   );

   // Head command is masked to zero when nothing valid is queued.
   assign cq.command_out  = empty ? '0 : head_cmd;
   assign cq.pause_READ   = full;
   assign cq.pause_DECODE = empty;
   assign cq.half_pending = half_q;
   assign cq.count        = count_q;
   assign cq.overflow     = ovf_q;
   assign cq.underflow    = unf_q;

endmodule

// File: tb/tb_command_queue.sv
// Bench for command_queue: queue-based reference model checked every cycle,
// plus directed literal expectations at the interesting points.
module tb_command_queue;
   import command_queue_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   command_queue_if cq ();

   command_queue dut (
      .clk   (clk),
      .reset (reset),
      .cq    (cq)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [27:0] m_q [$];
   logic        m_half = 1'b0;
   logic [13:0] m_high = '0;
   logic        m_ovf  = 1'b0;
   logic        m_unf  = 1'b0;
   int          m_sz;

   task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [13:0] w(input int i);
      return 14'(i * 37 + 5);
   endfunction

   // Reference model: a plain queue of commands plus the half-word holder.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_q.delete();
         m_half = 1'b0;
         m_high = '0;
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
      end else if (cq.flush) begin
         m_q.delete();
         m_half = 1'b0;
      end else begin
         m_sz = m_q.size();
         if (cq.comm_write && m_sz == 8) m_ovf = 1'b1;
         if (cq.comm_read  && m_sz == 0) m_unf = 1'b1;
         if (cq.comm_read  && m_sz > 0)  void'(m_q.pop_front());
         if (cq.comm_write && m_sz < 8) begin
            if (m_half) begin
               m_q.push_back({m_high, cq.word_in});
               m_half = 1'b0;
            end else begin
               m_high = cq.word_in;
               m_half = 1'b1;
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("cmd_model",   cq.command_out, (m_q.size() > 0) ? m_q[0] : 28'h0);
      check("cnt_model",   28'(cq.count), 28'(m_q.size()));
      check("pread_model", 28'(cq.pause_READ), 28'(m_q.size() == 8));
      check("pdec_model",  28'(cq.pause_DECODE), 28'(m_q.size() == 0));
      check("half_model",  28'(cq.half_pending), 28'(m_half));
      check("ovf_model",   28'(cq.overflow), 28'(m_ovf));
      check("unf_model",   28'(cq.underflow), 28'(m_unf));
   end

   task automatic cyc(input logic wr, input logic [13:0] d, input logic rd, input logic fl);
      cq.comm_write = wr;
      cq.word_in    = d;
      cq.comm_read  = rd;
      cq.flush      = fl;
      @(posedge clk);
      #1;
      cq.comm_write = 1'b0;
      cq.comm_read  = 1'b0;
      cq.flush      = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_cnt"},  28'(cq.count), 28'd0);
      check({tag, "_half"}, 28'(cq.half_pending), 28'd0);
      check({tag, "_prd"},  28'(cq.pause_READ), 28'd0);
      check({tag, "_pdec"}, 28'(cq.pause_DECODE), 28'd1);
      check({tag, "_ovf"},  28'(cq.overflow), 28'd0);
      check({tag, "_unf"},  28'(cq.underflow), 28'd0);
      check({tag, "_cmd"},  cq.command_out, 28'h0);
   endtask

   initial begin
      cq.comm_write = 1'b0;
      cq.word_in    = '0;
      cq.comm_read  = 1'b0;
      cq.flush      = 1'b0;
      #23;
      check_reset_vals("por");
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Basic two-word assembly.
      cyc(1'b1, 14'h1234, 1'b0, 1'b0);
      check("half_after_first", 28'(cq.half_pending), 28'd1);
      check("pdec_after_first", 28'(cq.pause_DECODE), 28'd1);
      cyc(1'b1, 14'h0ABC, 1'b0, 1'b0);
      check("cnt_first_cmd",  28'(cq.count), 28'd1);
      check("pdec_first_cmd", 28'(cq.pause_DECODE), 28'd0);
      check("cmd_first",      cq.command_out, 28'h48D0ABC);
      cyc(1'b0, '0, 1'b1, 1'b0);
      check("cnt_after_pop", 28'(cq.count), 28'd0);

      // Fill to full, then overflow.
      for (int i = 0; i < 16; i++) cyc(1'b1, w(i), 1'b0, 1'b0);
      check("full_pread", 28'(cq.pause_READ), 28'd1);
      check("full_cnt",   28'(cq.count), 28'd8);
      check("full_head",  cq.command_out, 28'h001402A);
      cyc(1'b1, 14'h3FFF, 1'b0, 1'b0);
      check("ovf_set",    28'(cq.overflow), 28'd1);
      check("ovf_half",   28'(cq.half_pending), 28'd0);
      check("ovf_cnt",    28'(cq.count), 28'd8);

      // Write and read together while full: write dropped, read taken.
      cyc(1'b1, 14'h1111, 1'b1, 1'b0);
      check("fullrw_cnt",  28'(cq.count), 28'd7);
      check("fullrw_head", cq.command_out, 28'h013C074);
      check("fullrw_half", 28'(cq.half_pending), 28'd0);
      for (int k = 0; k < 7; k++) cyc(1'b0, '0, 1'b1, 1'b0);
      check("drain_pdec", 28'(cq.pause_DECODE), 28'd1);
      check("drain_unf",  28'(cq.underflow), 28'd0);

      // Empty queue: completing write plus read, no bypass.
      cyc(1'b1, 14'h0111, 1'b0, 1'b0);
      cyc(1'b1, 14'h0222, 1'b1, 1'b0);
      check("nobyp_cnt", 28'(cq.count), 28'd1);
      check("nobyp_unf", 28'(cq.underflow), 28'd1);
      check("nobyp_cmd", cq.command_out, 28'h0444222);
      cyc(1'b0, '0, 1'b1, 1'b0);

      // Flush drops a half-assembled command and beats a same-cycle write.
      cyc(1'b1, 14'h2AAA, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b1);
      check("flush_half", 28'(cq.half_pending), 28'd0);
      check("flush_cnt",  28'(cq.count), 28'd0);
      cyc(1'b1, 14'h0555, 1'b1, 1'b1);
      check("flushw_half", 28'(cq.half_pending), 28'd0);
      check("flush_unf",   28'(cq.underflow), 28'd1);
      cyc(1'b1, 14'h0001, 1'b0, 1'b0);
      cyc(1'b1, 14'h0002, 1'b0, 1'b0);
      check("postflush_cmd", cq.command_out, 28'h0004002);
      check("postflush_ovf", 28'(cq.overflow), 28'd1);
      cyc(1'b0, '0, 1'b1, 1'b0);

      // Stream 20 commands with overlapping pops to wrap the pointers.
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, w(100 + 2 * i), 1'b0, 1'b0);
         cyc(1'b1, w(101 + 2 * i), (i >= 3), 1'b0);
      end
      check("wrap_cnt", 28'(cq.count), 28'd3);
      check("wrap_head", cq.command_out, {w(134), w(135)});

      // Asynchronous reset in the middle of assembly.
      cyc(1'b1, 14'h0777, 1'b0, 1'b0);
      check("mid_half", 28'(cq.half_pending), 28'd1);
      #3;
      reset = 1'b0;
      #1;
      check_reset_vals("async");
      #7;
      reset = 1'b1;
      @(posedge clk);
      #1;
      cyc(1'b1, 14'h0003, 1'b0, 1'b0);
      cyc(1'b1, 14'h0004, 1'b0, 1'b0);
      check("after_rst_cmd", cq.command_out, 28'h000C004);
      cyc(1'b0, '0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
